// File: rtl/bitfile_controller.sv
// ============================================================================
// Module      : bitfile_controller
// Description : Configuration controller for the FPGA fabric model. Captures
//               an 8-bit configuration word into a holding register and
//               exposes it as four registered 2-bit control selects.
//               Optional serial shadow loading is enabled by defining the
//               macro BITFILE_SERIAL_CFG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitfile_controller #(
  // Configuration word width; only 8 (four 2-bit selects) is supported.
  parameter int               CFG_W     = 8,
  // Configuration register contents after reset.
  parameter logic [CFG_W-1:0] RESET_CFG = 8'h00
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [CFG_W-1:0] bitfile,
  input  logic             load,
  input  logic             cfg_lock,
`ifdef BITFILE_SERIAL_CFG_EN
  input  logic             cfg_shift,
  input  logic             cfg_sin,
  input  logic             cfg_serial_sel,
  output logic             cfg_sout,
`endif
  output logic [1:0]       Control_signal1,
  output logic [1:0]       Control_signal2,
  output logic [1:0]       Control_signal3,
  output logic [1:0]       Control_signal4,
  output logic             cfg_valid,
  output logic             cfg_locked,
  output logic             cfg_update
);

  // Holding register and status flags.
  logic [CFG_W-1:0] cfg_q;
  logic [CFG_W-1:0] cfg_d;
  logic             valid_q;
  logic             valid_d;
  logic             locked_q;
  logic             locked_d;
  logic             update_q;
  logic             update_d;

  // Word that an accepted load would commit.
  logic [CFG_W-1:0] load_src;
  // A load is honoured only while the lock flag is still clear.
  logic             load_accept;

`ifdef BITFILE_SERIAL_CFG_EN
  logic [CFG_W-1:0] shadow_q;
  logic [CFG_W-1:0] shadow_d;

  // Shadow shifts MSB-first regardless of the lock; a load in the same cycle
  // sees the pre-shift value because load_src reads shadow_q.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_shift) begin
      shadow_d = {shadow_q[CFG_W-2:0], cfg_sin};
    end
  end

  // Shadow shift register state.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign load_src = cfg_serial_sel ? shadow_q : bitfile;
  assign cfg_sout = shadow_q[CFG_W-1];
`else
  assign load_src = bitfile;
`endif

  assign load_accept = load & ~locked_q;

  // Next-state logic: commit on accepted load, flag a change, latch the lock.
  always_comb begin
    cfg_d    = cfg_q;
    valid_d  = valid_q;
    locked_d = locked_q;
    update_d = 1'b0;
    if (load_accept) begin
      cfg_d    = load_src;
      valid_d  = 1'b1;
      update_d = (load_src != cfg_q);
    end
    if (cfg_lock) begin
      locked_d = 1'b1;
    end
  end

  // Configuration register and flags; reset is asynchronous.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cfg_q    <= RESET_CFG;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      update_q <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      update_q <= update_d;
    end
  end

  // Outputs are straight slices of flops, so they cannot glitch.
  assign Control_signal1 = cfg_q[1:0];
  assign Control_signal2 = cfg_q[3:2];
  assign Control_signal3 = cfg_q[5:4];
  assign Control_signal4 = cfg_q[7:6];
  assign cfg_valid       = valid_q;
  assign cfg_locked      = locked_q;
  assign cfg_update      = update_q;

endmodule

`default_nettype wire

// File: tb/tb_bitfile_controller.sv
// ============================================================================
// Module      : tb_bitfile_controller
// Description : Self-checking bench for bitfile_controller: directed scenario
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitfile_controller;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic [7:0] bitfile;
  logic       load;
  logic       cfg_lock;
  logic       cfg_shift;
  logic       cfg_sin;
  logic       cfg_serial_sel;
  logic       cfg_sout;
  logic [1:0] Control_signal1, Control_signal2, Control_signal3, Control_signal4;
  logic       cfg_valid, cfg_locked, cfg_update;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  logic [7:0] m_cfg;
  logic       m_valid, m_locked, m_update;
  logic [7:0] m_shadow;

  bitfile_controller dut (
    .CLK             (CLK),
    .RST_n           (RST_n),
    .bitfile         (bitfile),
    .load            (load),
    .cfg_lock        (cfg_lock),
`ifdef BITFILE_SERIAL_CFG_EN
    .cfg_shift       (cfg_shift),
    .cfg_sin         (cfg_sin),
    .cfg_serial_sel  (cfg_serial_sel),
    .cfg_sout        (cfg_sout),
`endif
    .Control_signal1 (Control_signal1),
    .Control_signal2 (Control_signal2),
    .Control_signal3 (Control_signal3),
    .Control_signal4 (Control_signal4),
    .cfg_valid       (cfg_valid),
    .cfg_locked      (cfg_locked),
    .cfg_update      (cfg_update)
  );

`ifndef BITFILE_SERIAL_CFG_EN
  assign cfg_sout = 1'b0;
`endif

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_word();
    return {Control_signal4, Control_signal3, Control_signal2, Control_signal1};
  endfunction

  // Compare every output against the model.
  task automatic check_all(input string tag);
    check({tag, ".cs1"},    {30'd0, Control_signal1}, {30'd0, m_cfg[1:0]});
    check({tag, ".cs2"},    {30'd0, Control_signal2}, {30'd0, m_cfg[3:2]});
    check({tag, ".cs3"},    {30'd0, Control_signal3}, {30'd0, m_cfg[5:4]});
    check({tag, ".cs4"},    {30'd0, Control_signal4}, {30'd0, m_cfg[7:6]});
    check({tag, ".valid"},  {31'd0, cfg_valid},  {31'd0, m_valid});
    check({tag, ".locked"}, {31'd0, cfg_locked}, {31'd0, m_locked});
    check({tag, ".update"}, {31'd0, cfg_update}, {31'd0, m_update});
`ifdef BITFILE_SERIAL_CFG_EN
    check({tag, ".sout"},   {31'd0, cfg_sout},   {31'd0, m_shadow[7]});
`endif
  endtask

  task automatic model_reset();
    m_cfg    = 8'h00;
    m_valid  = 1'b0;
    m_locked = 1'b0;
    m_update = 1'b0;
    m_shadow = 8'h00;
  endtask

  // Model of one rising edge using the inputs presented for that edge.
  task automatic model_edge();
    logic [7:0] src;
    logic       accept;
    src = bitfile;
`ifdef BITFILE_SERIAL_CFG_EN
    if (cfg_serial_sel) src = m_shadow;
`endif
    accept   = load && !m_locked;
    m_update = accept && (src != m_cfg);
    if (accept) begin
      m_cfg   = src;
      m_valid = 1'b1;
    end
    if (cfg_lock) m_locked = 1'b1;
    if (cfg_shift) m_shadow = {m_shadow[6:0], cfg_sin};
  endtask

  // Present inputs at the falling edge, clock once, compare just after.
  task automatic cycle(input logic ld, input logic lk, input logic [7:0] bf,
                       input logic sh, input logic si, input logic sel,
                       input string tag);
    @(negedge CLK);
    load = ld; cfg_lock = lk; bitfile = bf;
    cfg_shift = sh; cfg_sin = si; cfg_serial_sel = sel;
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges and verify it acts without a clock.
  task automatic async_reset(input string tag);
    @(posedge CLK);
    #2;
    RST_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge CLK);
    load = 1'b0; cfg_lock = 1'b0; cfg_shift = 1'b0;
    @(posedge CLK);
    #1;
    check_all({tag, ".hold"});
    @(negedge CLK);
    RST_n = 1'b1;
  endtask

  initial begin
    RST_n = 1'b0; bitfile = 8'hFF; load = 1'b0; cfg_lock = 1'b0;
    cfg_shift = 1'b0; cfg_sin = 1'b0; cfg_serial_sel = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge CLK);
    RST_n = 1'b1;

    // Directed scenario.
    cycle(1, 0, 8'b11101110, 0, 0, 0, "ld_EE");
    check("ld_EE.word", {24'd0, dut_word()}, 32'hEE);
    check("ld_EE.cs1",  {30'd0, Control_signal1}, 32'h2);
    check("ld_EE.upd",  {31'd0, cfg_update}, 32'h1);
    cycle(0, 0, 8'h00, 0, 0, 0, "idle");
    check("idle.upd",   {31'd0, cfg_update}, 32'h0);
    cycle(1, 0, 8'b11101110, 0, 0, 0, "reload");
    check("reload.upd", {31'd0, cfg_update}, 32'h0);
    check("reload.word", {24'd0, dut_word()}, 32'hEE);
    cycle(1, 0, 8'b00011011, 0, 0, 0, "ld_1B");
    check("ld_1B.cs1", {30'd0, Control_signal1}, 32'h3);
    check("ld_1B.cs4", {30'd0, Control_signal4}, 32'h0);
    cycle(1, 1, 8'hA5, 0, 0, 0, "lock_A5");
    check("lock_A5.word", {24'd0, dut_word()}, 32'hA5);
    check("lock_A5.lck",  {31'd0, cfg_locked}, 32'h1);
    cycle(1, 0, 8'h3C, 0, 0, 0, "locked_3C");
    check("locked_3C.word", {24'd0, dut_word()}, 32'hA5);
    check("locked_3C.upd",  {31'd0, cfg_update}, 32'h0);
    async_reset("rst_locked");
    check("rst_locked.word", {24'd0, dut_word()}, 32'h00);

`ifdef BITFILE_SERIAL_CFG_EN
    begin
      logic [7:0] pat;
      pat = 8'b11101110;
      for (int i = 7; i >= 0; i--) cycle(0, 0, 8'h00, 1, pat[i], 0, "shift");
      check("ser.sout", {31'd0, cfg_sout}, 32'h1);
      cycle(1, 0, 8'h00, 0, 0, 1, "ser_load");
      check("ser_load.word", {24'd0, dut_word()}, 32'hEE);
    end
`endif

    // Randomized traffic with periodic asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] bf;
      if (i % 97 == 96) begin
        async_reset("rand_rst");
      end else begin
        bf = ($urandom % 4 == 0) ? m_cfg : 8'($urandom);
        cycle(($urandom % 3) != 0, ($urandom % 40) == 0, bf,
              1'($urandom), 1'($urandom), 1'($urandom), "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net in case the run stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/bitfile_controller.md
Name: bitfile_controller

Overview:
- Configuration controller for the FPGA fabric model.
- Captures an 8-bit configuration word ("bitfile") into a holding register.
- Decodes the held word into four 2-bit control selects that drive the downstream configurable blocks (mux/LUT select inputs).
- Outputs are registered and glitch-free, and change only on an accepted load.

Parameters:
- CFG_W, 8, configuration word width; fixed at 2 * number of control outputs (4). Other values are unsupported.
- RESET_CFG, 8'h00, value of the configuration register after reset.

Ports:
- CLK  input  1  system clock; rising edge active.
- RST_n  input  1  asynchronous active-low reset.
- bitfile  input  8  parallel configuration word.
- load  input  1  when high at a rising edge, commits a new word into the configuration register.
- cfg_lock  input  1  when high at a rising edge, sets the lock flag; lock clears only on reset.
- Control_signal1  output  2  equals cfg_reg[1:0].
- Control_signal2  output  2  equals cfg_reg[3:2].
- Control_signal3  output  2  equals cfg_reg[5:4].
- Control_signal4  output  2  equals cfg_reg[7:6].
- cfg_valid  output  1  high once at least one load has been accepted since reset.
- cfg_locked  output  1  current state of the lock flag.
- cfg_update  output  1  one-cycle pulse in the cycle after an accepted load whose word differs from the previous cfg_reg.

Behaviour:
- Reset (RST_n low, asynchronous, takes effect without a clock edge):
  - cfg_reg = RESET_CFG, so all Control_signalN = 2'b00 by default.
  - cfg_valid = 0, cfg_locked = 0, cfg_update = 0.
- Deassertion of RST_n is sampled at the next CLK edge. No operation is accepted in the reset cycle.
- Accepted load: load = 1 and cfg_locked = 0 at a rising edge.
  - cfg_reg <= selected source word; cfg_valid <= 1.
  - cfg_update <= (new word != old cfg_reg).
- Latency: outputs reflect the new word one cycle after load is sampled (directly from flops; no combinational path from bitfile to outputs).
- load low: cfg_reg holds; bitfile changes have no effect.
- cfg_update: high for exactly one cycle per accepted, differing load. It is 0 on every other cycle, including:
  - a reload of an identical word;
  - any load while locked.
- Lock:
  - cfg_lock = 1 at an edge sets cfg_locked <= 1.
  - While locked, all loads are ignored; cfg_reg, cfg_valid and cfg_update behave as if load were 0.
- Simultaneous load and cfg_lock at the same edge, while unlocked: the load is accepted AND the lock is set. The committed word is the final word.
- Decoding is a pure bit slice: Control_signalN = cfg_reg[2N-1:2N-2]. There is no arithmetic and no re-encoding.
- Reset asserted mid-operation (including while locked) returns every output to its reset value immediately.
- Back-to-back loads on consecutive cycles are all accepted; each produces its own cfg_update decision.

Optional Feature:
- Macro: BITFILE_SERIAL_CFG_EN.
- Defined: adds three inputs and one output.
  - Inputs: cfg_shift (1), cfg_sin (1), cfg_serial_sel (1).
  - Output: cfg_sout (1).
  - Adds an 8-bit shadow shift register, reset to 8'h00.
  - cfg_shift = 1 at an edge: shadow <= {shadow[6:0], cfg_sin}, i.e. MSB-first. The lock does not affect shifting.
  - cfg_sout = shadow[7], combinational from the flop.
  - Load source is the shadow register when cfg_serial_sel = 1, otherwise bitfile.
  - Load and shift at the same edge: cfg_reg takes the pre-shift shadow value, and the shift still occurs.
- Undefined: none of these ports exist; the load source is always bitfile.

Test Plan:
- Reset with bitfile = 8'hFF and load = 0 -> all Control_signalN = 00, cfg_valid = 0, cfg_locked = 0, cfg_update = 0.
- Drive bitfile = 8'b11101110 and pulse load for 1 cycle -> next cycle:
  - CS1 = 10, CS2 = 11, CS3 = 10, CS4 = 11;
  - cfg_valid = 1;
  - cfg_update pulses for 1 cycle.
- Reload of 8'b11101110 -> outputs unchanged and cfg_update stays 0.
- Then bitfile = 8'b00011011 with load held 1 -> CS1 = 11, CS2 = 10, CS3 = 01, CS4 = 00.
- Assert cfg_lock together with a load of 8'hA5 -> A5 is committed (CS1 = 01, CS2 = 01, CS3 = 10, CS4 = 10) and cfg_locked = 1. A subsequent load of 8'h3C is ignored.
- Assert RST_n low between clock edges while locked -> outputs go to 00 and flags clear immediately.
- With BITFILE_SERIAL_CFG_EN: shift in 1,1,1,0,1,1,1,0, then load with cfg_serial_sel = 1 -> same outputs as 8'b11101110. After the eighth shift, cfg_sout = 1.
